// File: rtl/l2cache_pkg.sv
// Shared L2 cache definitions: way geometry, PLRU state type, response payload.
package l2cache_pkg;

  localparam int unsigned L2_WAYS  = 4;
  localparam int unsigned L2_WAY_W = 2;
  localparam int unsigned PLRU_W   = 3;

  typedef logic [PLRU_W-1:0]   plru_t;
  typedef logic [L2_WAY_W-1:0] way_idx_t;

  typedef struct packed {
    way_idx_t way;
    logic     hit;
  } way_resp_t;

  // Lowest-numbered way whose valid bit is clear; 0 when all ways are valid.
  function automatic way_idx_t first_invalid(input logic [L2_WAYS-1:0] vld);
    way_idx_t r;
    r = '0;
    for (int i = int'(L2_WAYS) - 1; i >= 0; i--) begin
      if (!vld[i]) r = way_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_plru_tree.sv
// 4-way tree pseudo-LRU: victim lookup and touch (next-state) logic, purely combinational.
module l2_plru_tree
  import l2cache_pkg::*;
(
  input  plru_t    state,
  input  way_idx_t touch_way,
  output way_idx_t victim,
  output plru_t    next_state
);

  // b0 picks the half, b1/b2 pick the way inside the 0/1 and 2/3 halves.
  always_comb begin
    victim = state[0] ? {1'b1, state[2]} : {1'b0, state[1]};
  end

  // Point every tree bit on the path away from the touched way.
  always_comb begin
    next_state    = state;
    next_state[0] = ~touch_way[1];
    if (touch_way[1]) next_state[2] = ~touch_way[0];
    else              next_state[1] = ~touch_way[0];
  end

endmodule

// File: rtl/l2_plru_way_sel.sv
// L2 victim-way selector: per-set PLRU state, hit/victim mux and registered way result.
// Optional build macro: L2_PLRU_INVALID_FIRST_EN (miss prefers the lowest invalid way).
module l2_plru_way_sel
  import l2cache_pkg::*;
#(
  parameter int unsigned SETS  = 64,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDX_W-1:0]   req_index,
  input  logic               req_hit,
  input  logic [1:0]         req_hit_way,
  input  logic [L2_WAYS-1:0] req_way_vld,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_way,
  output logic [IDX_W-1:0]   resp_index,
  output logic               resp_hit
);

  plru_t     plru [SETS];
  plru_t     cur_state;
  plru_t     touched_state;
  way_idx_t  victim;
  way_idx_t  sel_way;
  logic      accept;
  way_resp_t resp_q;

  assign req_ready = ~flush & (~resp_valid | resp_ready);
  assign accept    = req_valid & req_ready;
  assign cur_state = plru[req_index];

  l2_plru_tree u_tree (
    .state      (cur_state),
    .touch_way  (sel_way),
    .victim     (victim),
    .next_state (touched_state)
  );

`ifdef L2_PLRU_INVALID_FIRST_EN
  always_comb begin
    sel_way = victim;
    if (req_hit)                        sel_way = way_idx_t'(req_hit_way);
    else if (req_way_vld != 4'b1111)    sel_way = first_invalid(req_way_vld);
  end
`else
  logic unused_way_vld;
  assign unused_way_vld = ^req_way_vld;

  always_comb begin
    sel_way = victim;
    if (req_hit) sel_way = way_idx_t'(req_hit_way);
  end
`endif

  // Flush has priority; it also blocks acceptance through req_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SETS; i++) plru[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < SETS; i++) plru[i] <= '0;
    end else if (accept) begin
      plru[req_index] <= touched_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_q     <= '0;
      resp_index <= '0;
    end else if (accept) begin
      resp_valid     <= 1'b1;
      resp_q.way     <= sel_way;
      resp_q.hit     <= req_hit;
      resp_index     <= req_index;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign resp_way = resp_q.way;
  assign resp_hit = resp_q.hit;

endmodule

// File: tb/tb_l2_plru_way_sel.sv
// Scoreboard bench for l2_plru_way_sel: directed scenarios plus randomized traffic vs a PLRU tree model.
module tb_l2_plru_way_sel;

  localparam int unsigned SETS  = 64;
  localparam int unsigned IDX_W = $clog2(SETS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [IDX_W-1:0] req_index = '0;
  logic             req_hit = 1'b0;
  logic [1:0]       req_hit_way = '0;
  logic [3:0]       req_way_vld = 4'b1111;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [1:0]       resp_way;
  logic [IDX_W-1:0] resp_index;
  logic             resp_hit;

  l2_plru_way_sel #(.SETS(SETS), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_hit     (req_hit),
    .req_hit_way (req_hit_way),
    .req_way_vld (req_way_vld),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_way    (resp_way),
    .resp_index  (resp_index),
    .resp_hit    (resp_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int way;
    int idx;
    int hit;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_valid = 1'b0;

  // Reference model: per set, which half holds the victim and, per half, which way.
  int half_ptr [SETS];
  int lo_ptr   [SETS];
  int hi_ptr   [SETS];

  function automatic void model_clear();
    for (int s = 0; s < int'(SETS); s++) begin
      half_ptr[s] = 0;
      lo_ptr[s]   = 0;
      hi_ptr[s]   = 0;
    end
  endfunction

  function automatic int model_victim(input int s);
    if (half_ptr[s] == 0) return lo_ptr[s];
    return 2 + hi_ptr[s];
  endfunction

  function automatic void model_touch(input int s, input int w);
    half_ptr[s] = (w >= 2) ? 0 : 1;
    if (w >= 2) hi_ptr[s] = (w == 2) ? 1 : 0;
    else        lo_ptr[s] = (w == 0) ? 1 : 0;
  endfunction

  function automatic int model_select(input int s, input bit hit, input int hw, input bit [3:0] vld);
    if (hit) return hw;
`ifdef L2_PLRU_INVALID_FIRST_EN
    for (int i = 0; i < 4; i++) if (vld[i] == 1'b0) return i;
`endif
    return model_victim(s);
  endfunction

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // One bus cycle: drive after the edge, then predict what the next edge does.
  task automatic cyc(input bit v, input int idx, input bit hit, input int hw,
                     input bit [3:0] vld, input bit fl, input bit rr, input int force_way);
    bit   exp_ready;
    bit   acc;
    exp_t e;
    @(posedge clk); #1;
    req_valid   = v;
    req_index   = IDX_W'(idx);
    req_hit     = hit;
    req_hit_way = 2'(hw);
    req_way_vld = vld;
    flush       = fl;
    resp_ready  = rr;
    @(negedge clk); #2;
    exp_ready = !fl && (!exp_valid || rr);
    check("req_ready", int'(req_ready), int'(exp_ready));
    acc = v && exp_ready;
    if (acc) begin
      e.way = model_select(idx, hit, hw, vld);
      if (force_way >= 0) e.way = force_way;
      e.idx = idx;
      e.hit = int'(hit);
      sb.push_back(e);
      model_touch(idx, model_select(idx, hit, hw, vld));
    end
    if (fl) model_clear();
    exp_valid = acc ? 1'b1 : (rr ? 1'b0 : exp_valid);
  endtask

  // Monitor: compares the presented response every cycle, retires it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("resp_valid", int'(resp_valid), int'(exp_valid));
        if (resp_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 1, 0);
          end else begin
            check("resp_way", int'(resp_way), sb[0].way);
            check("resp_index", int'(resp_index), sb[0].idx);
            check("resp_hit", int'(resp_hit), sb[0].hit);
            if (resp_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int w0;
    model_clear();
    #12;
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_way", int'(resp_way), 0);
    check("rst_resp_index", int'(resp_index), 0);
    check("rst_resp_hit", int'(resp_hit), 0);
    @(negedge clk); rst_n = 1'b1;

    // Four misses to set 5 walk the tree: 0, 2, 1, 3
    cyc(1, 5, 0, 0, 4'hF, 0, 1, 0);
    cyc(1, 5, 0, 0, 4'hF, 0, 1, 2);
    cyc(1, 5, 0, 0, 4'hF, 0, 1, 1);
    cyc(1, 5, 0, 0, 4'hF, 0, 1, 3);
    cyc(1, 5, 0, 0, 4'hF, 0, 1, 0);

    // Hit way 2 in set 7, then miss in set 7
    cyc(1, 7, 1, 2, 4'hF, 0, 1, 2);
    cyc(1, 7, 0, 3, 4'hF, 0, 1, 0);

    // Stall: resp held for several cycles, then accepted on release
    cyc(1, 12, 0, 0, 4'hF, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 13, 1, 1, 4'hF, 0, 0, -1);
    cyc(1, 13, 1, 1, 4'hF, 0, 1, 1);

    // Touch sets 1 and 9, flush with a request, then set 9 must restart at way 0
    cyc(1, 1, 0, 0, 4'hF, 0, 1, -1);
    cyc(1, 9, 0, 0, 4'hF, 0, 1, -1);
    cyc(1, 9, 0, 0, 4'hF, 1, 1, -1);
    cyc(1, 9, 0, 0, 4'hF, 0, 1, 0);
    cyc(1, 1, 0, 0, 4'hF, 0, 1, 0);

    // Flush while a response is stalled keeps the response
    cyc(1, 30, 1, 3, 4'hF, 0, 0, 3);
    cyc(0, 0, 0, 0, 4'hF, 1, 0, -1);
    cyc(0, 0, 0, 0, 4'hF, 0, 1, -1);
    cyc(1, 30, 0, 0, 4'hF, 0, 1, 0);

    // Miss with way 2 invalid in a fresh set
`ifdef L2_PLRU_INVALID_FIRST_EN
    cyc(1, 20, 0, 0, 4'b1011, 0, 1, 2);
`else
    cyc(1, 20, 0, 0, 4'b1011, 0, 1, 0);
`endif
    cyc(0, 0, 0, 0, 4'hF, 0, 1, -1);

    // Asynchronous reset with a stalled response in flight
    cyc(1, 5, 0, 0, 4'hF, 0, 0, -1);
    @(posedge clk); #3;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_resp_valid", int'(resp_valid), 0);
    sb.delete();
    exp_valid = 1'b0;
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 5, 0, 0, 4'hF, 0, 1, 0);

    // Randomized traffic on a few colliding sets
    for (int n = 0; n < 2000; n++) begin
      w0 = int'($urandom_range(0, 3));
      cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)) * 17,
          $urandom_range(0, 1) == 1, w0, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), -1);
    end

    // Drain, bounded
    for (int n = 0; n < 10 && (exp_valid || sb.size() != 0); n++)
      cyc(0, 0, 0, 0, 4'hF, 0, 1, -1);
    check("drain_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
